// File: rtl/serial_ripple_subtractor.sv
// -----------------------------------------------------------------------------
// serial_ripple_subtractor
//   Bit-serial N-bit subtractor: Diff = (A - B - Bin) mod 2^N, Bout = borrow.
//   One bit position is resolved per clock, LSB first, through a single
//   full-subtractor cell. A start/busy/done handshake sequences operations.
//   Results are held stable between completions.
//
// Ports
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   operation request, sampled only while busy=0
//   A      in   N-bit minuend, captured on an accepted start
//   B      in   N-bit subtrahend, captured on an accepted start
//   Bin    in   borrow-in, captured on an accepted start
//   Diff   out  N-bit difference, updated on completion and held
//   Bout   out  final borrow, 1 iff A < B + Bin (unsigned)
//   busy   out  high while an operation is in flight (exactly N cycles)
//   done   out  single-cycle completion pulse
// -----------------------------------------------------------------------------
module serial_ripple_subtractor #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Bin,
    output logic [N-1:0] Diff,
    output logic         Bout,
    output logic         busy,
    output logic         done
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    // Full-subtractor cell: returns {borrow_out, difference_bit}.
    function automatic logic [1:0] fs_cell(input logic a, input logic b, input logic br);
        logic d;
        logic bo;
        d  = a ^ b ^ br;
        bo = (~a & b) | (~(a ^ b) & br);
        return {bo, d};
    endfunction

    state_t         state_q, state_d;
    logic [N-1:0]   a_q, a_d;
    logic [N-1:0]   b_q, b_d;
    logic           br_q, br_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [N-1:0]   diff_sr_q, diff_sr_d;
    logic [N-1:0]   diff_q, diff_d;
    logic           bout_q, bout_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    logic [1:0]     cell_s;
    logic [N-1:0]   diff_full_s;

    // Current bit through the cell, and the difference including this bit.
    always_comb begin
        cell_s              = fs_cell(a_q[idx_q], b_q[idx_q], br_q);
        diff_full_s         = diff_sr_q;
        diff_full_s[idx_q]  = cell_s[0];
    end

    // Next-state and next-output logic for the IDLE/CALC sequencer.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        br_d      = br_q;
        idx_d     = idx_q;
        diff_sr_d = diff_sr_q;
        diff_d    = diff_q;
        bout_d    = bout_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d       = A;
                    b_d       = B;
                    br_d      = Bin;
                    idx_d     = {IW{1'b0}};
                    diff_sr_d = {N{1'b0}};
                    busy_d    = 1'b1;
                    state_d   = CALC;
                end else begin
                    busy_d    = 1'b0;
                end
            end
            CALC: begin
                diff_sr_d = diff_full_s;
                br_d      = cell_s[1];
                if (idx_q == LAST_IDX) begin
                    // Final bit: publish the full result and hand back control.
                    diff_d  = diff_full_s;
                    bout_d  = cell_s[1];
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    idx_d   = {IW{1'b0}};
                    state_d = IDLE;
                end else begin
                    idx_d   = idx_q + IW'(1);
                end
            end
            default: begin
                busy_d  = 1'b0;
                idx_d   = {IW{1'b0}};
                state_d = IDLE;
            end
        endcase
    end

    // State, operand and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_q       <= {N{1'b0}};
            b_q       <= {N{1'b0}};
            br_q      <= 1'b0;
            idx_q     <= {IW{1'b0}};
            diff_sr_q <= {N{1'b0}};
            diff_q    <= {N{1'b0}};
            bout_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            br_q      <= br_d;
            idx_q     <= idx_d;
            diff_sr_q <= diff_sr_d;
            diff_q    <= diff_d;
            bout_q    <= bout_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign Diff = diff_q;
    assign Bout = bout_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// Bench for serial_ripple_subtractor: one N=4 and one N=8 instance share the
// clock and reset. A cycle-level model (arithmetic result plus a countdown of
// remaining busy cycles) is compared against both instances on every falling
// edge; directed literal checks pin the model.
module tb_serial_ripple_subtractor;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        start_v [2];
    logic [7:0]  a_v     [2];
    logic [7:0]  b_v     [2];
    logic        bin_v   [2];

    logic [3:0]  diff4;
    logic [7:0]  diff8;
    logic        bout4, bout8, busy4, busy8, done4, done8;
    logic [7:0]  diff_v  [2];
    logic        bout_v  [2];
    logic        busy_v  [2];
    logic        done_v  [2];

    int tests = 0;
    int fails = 0;

    // model state
    int          rem   [2];
    logic [7:0]  pd    [2];
    logic        pb    [2];
    logic [7:0]  ed    [2];
    logic        eb    [2];
    logic        ebusy [2];
    logic        edone [2];

    always #5 clk = ~clk;

    serial_ripple_subtractor #(.N(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]),
        .A(a_v[0][3:0]), .B(b_v[0][3:0]), .Bin(bin_v[0]),
        .Diff(diff4), .Bout(bout4), .busy(busy4), .done(done4)
    );

    serial_ripple_subtractor #(.N(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]),
        .A(a_v[1]), .B(b_v[1]), .Bin(bin_v[1]),
        .Diff(diff8), .Bout(bout8), .busy(busy8), .done(done8)
    );

    assign diff_v[0] = {4'b0000, diff4};
    assign diff_v[1] = diff8;
    assign bout_v[0] = bout4;
    assign bout_v[1] = bout8;
    assign busy_v[0] = busy4;
    assign busy_v[1] = busy8;
    assign done_v[0] = done4;
    assign done_v[1] = done8;

    task automatic check(input string nm, input logic [7:0] got, input logic [7:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Behavioural model: result from plain arithmetic, timing from a countdown.
    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            automatic int w    = (k == 0) ? 4 : 8;
            automatic int mask = (1 << w) - 1;
            automatic int av   = int'(a_v[k]) & mask;
            automatic int bv   = int'(b_v[k]) & mask;
            automatic int cv   = int'(bin_v[k]);
            if (!rst_n) begin
                rem[k] = 0; ed[k] = 8'h00; eb[k] = 1'b0;
                ebusy[k] = 1'b0; edone[k] = 1'b0;
            end else if (rem[k] == 0) begin
                edone[k] = 1'b0;
                if (start_v[k]) begin
                    pd[k]    = 8'((av - bv - cv) & mask);
                    pb[k]    = (av < bv + cv);
                    rem[k]   = w;
                    ebusy[k] = 1'b1;
                end
            end else begin
                rem[k] = rem[k] - 1;
                if (rem[k] == 0) begin
                    ed[k] = pd[k]; eb[k] = pb[k];
                    edone[k] = 1'b1; ebusy[k] = 1'b0;
                end
            end
        end
    end

    // Compare every DUT output against the model on each falling edge.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            check((k == 0) ? "n4_diff" : "n8_diff", diff_v[k], ed[k]);
            check((k == 0) ? "n4_bout" : "n8_bout", {7'd0, bout_v[k]}, {7'd0, eb[k]});
            check((k == 0) ? "n4_busy" : "n8_busy", {7'd0, busy_v[k]}, {7'd0, ebusy[k]});
            check((k == 0) ? "n4_done" : "n8_done", {7'd0, done_v[k]}, {7'd0, edone[k]});
        end
    end

    // Caller sits at a falling edge; returns at the falling edge where done=1.
    task automatic wait_done(input int k);
        int n;
        n = 0;
        while (!done_v[k] && n < 40) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (!done_v[k]) begin
            fails++;
            $display("FAIL done_timeout: dut %0d got done=0 expected done=1", k);
        end
    endtask

    task automatic run_op(input int k, input logic [7:0] a, input logic [7:0] b, input logic bin);
        start_v[k] = 1'b1; a_v[k] = a; b_v[k] = b; bin_v[k] = bin;
        @(negedge clk);
        start_v[k] = 1'b0;
        wait_done(k);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            start_v[k] = 1'b0; a_v[k] = 8'h00; b_v[k] = 8'h00; bin_v[k] = 1'b0;
        end
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("reset_diff", {4'h0, diff4}, 8'h00);
        check("reset_busy", {7'd0, busy4}, 8'h00);

        // 1: basic
        run_op(0, 8'h03, 8'h01, 1'b0);
        check("t1_diff", {4'h0, diff4}, 8'h02);
        check("t1_bout", {7'd0, bout4}, 8'h00);

        // 2: underflow / wrap cases
        run_op(0, 8'h01, 8'h02, 1'b0);
        check("t2a_diff", {4'h0, diff4}, 8'h0f);
        check("t2a_bout", {7'd0, bout4}, 8'h01);
        run_op(0, 8'h00, 8'h00, 1'b1);
        check("t2b_diff", {4'h0, diff4}, 8'h0f);
        check("t2b_bout", {7'd0, bout4}, 8'h01);
        run_op(0, 8'h0f, 8'h0f, 1'b1);
        check("t2c_diff", {4'h0, diff4}, 8'h0f);
        check("t2c_bout", {7'd0, bout4}, 8'h01);

        // 3: start held high while busy, operands change after acceptance
        start_v[0] = 1'b1; a_v[0] = 8'h06; b_v[0] = 8'h05; bin_v[0] = 1'b0;
        @(negedge clk);
        a_v[0] = 8'h0f; b_v[0] = 8'h00;
        wait_done(0);
        check("t3a_diff", {4'h0, diff4}, 8'h01);
        check("t3a_bout", {7'd0, bout4}, 8'h00);
        @(negedge clk);
        start_v[0] = 1'b0;
        check("t3_busy_after_done", {7'd0, busy4}, 8'h01);
        wait_done(0);
        check("t3b_diff", {4'h0, diff4}, 8'h0f);
        check("t3b_bout", {7'd0, bout4}, 8'h00);

        // 4: reset mid-operation, then clean restart
        start_v[0] = 1'b1; a_v[0] = 8'h0d; b_v[0] = 8'h0b; bin_v[0] = 1'b0;
        @(negedge clk);
        start_v[0] = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t4_rst_diff", {4'h0, diff4}, 8'h00);
        check("t4_rst_bout", {7'd0, bout4}, 8'h00);
        check("t4_rst_busy", {7'd0, busy4}, 8'h00);
        check("t4_rst_done", {7'd0, done4}, 8'h00);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        run_op(0, 8'h0d, 8'h0b, 1'b0);
        check("t4_diff", {4'h0, diff4}, 8'h02);
        check("t4_bout", {7'd0, bout4}, 8'h00);

        // 5: idle hold while inputs toggle
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            a_v[0] = 8'(i * 5); b_v[0] = 8'(15 - i); bin_v[0] = i[0];
            check("t5_done", {7'd0, done4}, 8'h00);
        end
        check("t5_diff", {4'h0, diff4}, 8'h02);
        check("t5_bout", {7'd0, bout4}, 8'h00);

        // 6: N=8 pinned vectors, then random back-to-back and spaced traffic
        @(negedge clk);
        run_op(1, 8'h00, 8'h00, 1'b1);
        check("t6a_diff", diff8, 8'hff);
        check("t6a_bout", {7'd0, bout8}, 8'h01);
        run_op(1, 8'h80, 8'h7f, 1'b0);
        check("t6b_diff", diff8, 8'h01);
        check("t6b_bout", {7'd0, bout8}, 8'h00);
        for (int i = 0; i < 220; i++) begin
            run_op(1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                   1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
